// File: rtl/midi_encoder_pkg.sv
// midi_encoder_pkg: MIDI message types, field widths and status-byte helpers shared by TX and RX paths
package midi_encoder_pkg;

    localparam int DATA_WIDTH    = 7;
    localparam int CHANNEL_WIDTH = 4;

    typedef enum logic [3:0] {
        NOTE_OFF       = 4'h8,
        NOTE_ON        = 4'h9,
        CONTROL_CHANGE = 4'hB
    } message_type_t;

    typedef struct packed {
        logic [3:0]            msg_type;
        logic [DATA_WIDTH-1:0] data_byte1;
        logic [DATA_WIDTH-1:0] data_byte2;
    } message_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STATUS,
        DATA1,
        DATA2
    } encoder_state_t;

    function automatic logic [7:0] compose_status(input logic [3:0] msg_type,
                                                  input logic [CHANNEL_WIDTH-1:0] ch);
        return {msg_type, ch};
    endfunction

    function automatic logic [3:0] status_type(input logic [7:0] status);
        return status[7:4];
    endfunction

    function automatic logic [CHANNEL_WIDTH-1:0] status_channel(input logic [7:0] status);
        return status[3:0];
    endfunction

    function automatic logic is_supported(input logic [3:0] msg_type);
        return msg_type == NOTE_OFF || msg_type == NOTE_ON || msg_type == CONTROL_CHANGE;
    endfunction

endpackage

// File: rtl/midi_message_fifo.sv
// midi_message_fifo: synchronous FIFO with full/empty flags; an extra pointer bit tells full from empty
module midi_message_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clock_50_000_000,
    input  logic             reset_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clock_50_000_000) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // pointer update, guarded so overflow and underflow are impossible
    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/midi_encoder.sv
// midi_encoder: serialises queued MIDI messages into status/data bytes with optional running status
module midi_encoder
    import midi_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH          = 4,
    parameter bit RUNNING_STATUS      = 1'b1,
    parameter bit NOTE_OFF_AS_NOTE_ON = 1'b1,
    parameter int RS_TIMEOUT_CYCLES   = 2_500_000
) (
    input  logic                     clock_50_000_000,
    input  logic                     reset_l,
    input  logic [CHANNEL_WIDTH-1:0] channel,
    input  message_t                 message,
    input  logic                     message_valid,
    output logic                     message_ready,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     message_dropped,
    output logic                     busy
);

    localparam int ENTRY_W = CHANNEL_WIDTH + $bits(message_t);
    localparam int TW      = $clog2(RS_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(RS_TIMEOUT_CYCLES - 1);

    encoder_state_t           state;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [ENTRY_W-1:0]       fifo_dout;
    logic [CHANNEL_WIDTH-1:0] hold_channel;
    message_t                 hold_message;
    logic [7:0]               last_status;
    logic                     rs_valid;
    logic [TW-1:0]            idle_count;
    logic [TW-1:0]            idle_next;
    logic                     eff_off;
    logic [3:0]               eff_type;
    logic [DATA_WIDTH-1:0]    eff_d2;
    logic [7:0]               status;
    logic                     skip_status;

    midi_message_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_50_000_000(clock_50_000_000),
        .reset_l         (reset_l),
        .push            (message_valid),
        .push_data       ({channel, message}),
        .pop             (fifo_pop),
        .pop_data        (fifo_dout),
        .full            (fifo_full),
        .empty           (fifo_empty)
    );

    assign message_ready = !fifo_full;
    assign busy          = !fifo_empty || state != IDLE;
    assign fifo_pop      = state == IDLE && !fifo_empty;
    assign eff_off       = NOTE_OFF_AS_NOTE_ON && hold_message.msg_type == NOTE_OFF;
    assign eff_type      = eff_off ? NOTE_ON : hold_message.msg_type;
    assign eff_d2        = eff_off ? '0 : hold_message.data_byte2;
    assign status        = compose_status(eff_type, hold_channel);
    assign skip_status   = RUNNING_STATUS && rs_valid && status == last_status;
    assign idle_next     = (state == IDLE && fifo_empty) ? ((idle_count == TMAX) ? TMAX : idle_count + 1'b1) : '0;

    // message sequencer with registered byte outputs and running-status bookkeeping
    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) begin
            state           <= IDLE;
            byte_out        <= '0;
            byte_valid      <= 1'b0;
            message_dropped <= 1'b0;
            rs_valid        <= 1'b0;
            last_status     <= '0;
            idle_count      <= '0;
            hold_channel    <= '0;
            hold_message    <= '0;
        end else begin
            message_dropped <= 1'b0;
            idle_count      <= idle_next;
            if (idle_next == TMAX) rs_valid <= 1'b0;
            case (state)
                IDLE: if (!fifo_empty) begin
                    {hold_channel, hold_message} <= fifo_dout;
                    state                        <= LOAD;
                end
                LOAD: if (!is_supported(eff_type)) begin
                    message_dropped <= 1'b1;
                    state           <= IDLE;
                end else begin
                    byte_out   <= skip_status ? {1'b0, hold_message.data_byte1} : status;
                    byte_valid <= 1'b1;
                    state      <= skip_status ? DATA1 : STATUS;
                end
                STATUS: if (byte_ready) begin
                    last_status <= status;
                    rs_valid    <= 1'b1;
                    byte_out    <= {1'b0, hold_message.data_byte1};
                    state       <= DATA1;
                end
                DATA1: if (byte_ready) begin
                    byte_out <= {1'b0, eff_d2};
                    state    <= DATA2;
                end
                DATA2: if (byte_ready) begin
                    byte_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
Transmit-side counterpart of the MIDI receive path. Accepts decoded MIDI messages (NOTE_ON, NOTE_OFF, CONTROL_CHANGE) plus a channel number and serialises each into status and data bytes for the UART transmitter. A small message FIFO absorbs bursts. Optional running status and NOTE_OFF-as-zero-velocity encoding reduce wire bytes.

Parameters:
FIFO_DEPTH, 4, message FIFO entries; power of 2, minimum 2.
RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last status byte sent.
NOTE_OFF_AS_NOTE_ON, 1, 1 = encode NOTE_OFF as NOTE_ON with data byte 2 = 0.
RS_TIMEOUT_CYCLES, 2_500_000, idle cycles (50 ms at 50 MHz) after which running status is invalidated.

Ports:
clock_50_000_000  in  1  system clock.
reset_l  in  1  reset, synchronous, active-low.
channel  in  4  MIDI channel, captured with message on accept.
message  in  message_t  type[3:0], data_byte1[6:0], data_byte2[6:0].
message_valid  in  1  upstream offers message.
message_ready  out  1  = !fifo_full; transfer on valid&&ready.
byte_out  out  8  byte to UART TX.
byte_valid  out  1  byte_out valid; held until byte_ready.
byte_ready  in  1  UART TX accepts; transfer on valid&&ready.
message_dropped  out  1  1-cycle pulse: popped message had an unsupported type.
busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (synchronous, reset_l low at the clock edge): FIFO empty, FSM IDLE, byte_out=0, byte_valid=0, message_dropped=0, busy=0, running status invalid, timeout counter 0. message_ready=1 in the first cycle after reset.
- Reset mid-byte: byte_valid drops at the reset edge and the partial message is abandoned. The UART owns any byte it has already accepted.
- FIFO: each entry is {channel, message}, 22 bits. Push on message_valid&&message_ready. No push when full. No pop when empty. Push and pop in the same cycle are allowed when neither full nor empty; occupancy is then unchanged.
- FSM states: IDLE, LOAD, STATUS, DATA1, DATA2.
- IDLE: if the FIFO is non-empty, pop into the holding register and go to LOAD.
- LOAD: compute the effective type. NOTE_OFF with NOTE_OFF_AS_NOTE_ON=1 becomes NOTE_ON with d2=0.
  - Effective type not in {8h, 9h, Bh}: pulse message_dropped, return to IDLE, running status unchanged.
  - Otherwise status = {type, channel}.
  - If RUNNING_STATUS && rs_valid && status == last_status: go to DATA1.
  - Else: go to STATUS.
- STATUS: byte_out=status, byte_valid=1. On handshake: last_status=status, rs_valid=1, go to DATA1.
- DATA1: byte_out={0, d1}. On handshake go to DATA2.
- DATA2: byte_out={0, d2}. On handshake go to IDLE.
- Data fields are always 7 bits, so bit 7 of every data byte is 0.
- byte_out and byte_valid are registered. byte_out is stable while byte_valid=1 and byte_ready=0.
- Back-to-back bytes: the next byte is valid in the cycle after a handshake.
- Latency: with the FIFO empty and FSM IDLE, byte_valid rises 3 cycles after the accept edge (push, pop, LOAD).
- Running-status timeout: the counter increments each cycle while FSM is IDLE and the FIFO is empty, and clears otherwise. On reaching RS_TIMEOUT_CYCLES-1, rs_valid=0 and the counter saturates. A channel change always forces a new status byte.
- CONTROL_CHANGE and NOTE_ON: d2 is sent unchanged. NOTE_ON with d2=0 from upstream is passed through.

Decomposition:
- Shared MIDI package: message_t, message_type_t encodings (NOTE_OFF=8h, NOTE_ON=9h, CONTROL_CHANGE=Bh), DATA_WIDTH=7, CHANNEL_WIDTH=4, and status-byte compose/split helpers. The receive side uses the same helpers.
- Sub-module midi_message_fifo: synchronous FIFO with parameterised width and depth, full/empty flags, synchronous active-low reset.

Test Plan:
- Single NOTE_ON, ch 3, key 3Ch, vel 64h, byte_ready=1 → bytes 93h, 3Ch, 64h on consecutive cycles; byte_valid rises 3 cycles after accept.
- Two NOTE_ON ch 0 (3Ch/40h, 3Eh/40h), RUNNING_STATUS=1 → 90h 3Ch 40h 3Eh 40h. Same stimulus with RUNNING_STATUS=0 → 90h 3Ch 40h 90h 3Eh 40h.
- NOTE_OFF ch 1, key 40h, NOTE_OFF_AS_NOTE_ON=1 → 91h 40h 00h. With NOTE_OFF_AS_NOTE_ON=0 → 81h 40h 00h.
- byte_ready=0 for 10 cycles with a CONTROL_CHANGE ch 2 07h/7Fh pending → B2h held stable, then B2h 07h 7Fh. Five further pushes with FIFO_DEPTH=4 → message_ready low after the 4th queued; no message lost or reordered.
- Unsupported type Eh, then NOTE_ON ch 0 → one message_dropped pulse, no bytes for Eh; NOTE_ON emitted with its status byte.
- NOTE_ON ch 0, idle for RS_TIMEOUT_CYCLES (set to 16 in bench), NOTE_ON ch 0 → status 90h re-sent. Reset asserted during DATA1 → byte_valid=0 at the next edge, FIFO empty, the next message starts with its status byte.
